reg_mgt_mc: RTL and testbench

Multi-channel register manager for the TLK2711 subsystem. It replaces the single-link register block and serves NUM_CH links from one CPU-side 64-bit register port. Each channel gets its own TX/RX configuration bank, sticky interrupt status with W1C clear and a mask, and a captured RX packet report. A global soft reset with programmable length and a read-valid strobe are added.

---
 rtl/reg_mgt_mc_if.sv | 24 ++
 rtl/reg_mgt_mc.sv | 279 +++++++++++++++++++++++++++
 tb/tb_reg_mgt_mc.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_mgt_mc_if.sv
// reg_mgt_mc_if: CPU-side 64-bit register port of the TLK2711 register manager.
//   i_reg_wen / i_reg_waddr / i_reg_wdata : write strobe, byte address, data
//   i_reg_ren / i_reg_raddr               : read strobe, byte address
//   o_reg_rdata / o_reg_rvalid            : read data and its one-cycle valid
// master = CPU side, slave = register manager.
interface reg_mgt_mc_if;
  logic        i_reg_wen;
  logic [15:0] i_reg_waddr;
  logic [63:0] i_reg_wdata;
  logic        i_reg_ren;
  logic [15:0] i_reg_raddr;
  logic [63:0] o_reg_rdata;
  logic        o_reg_rvalid;

  modport master (
    output i_reg_wen, i_reg_waddr, i_reg_wdata, i_reg_ren, i_reg_raddr,
    input  o_reg_rdata, o_reg_rvalid
  );

  modport slave (
    input  i_reg_wen, i_reg_waddr, i_reg_wdata, i_reg_ren, i_reg_raddr,
    output o_reg_rdata, o_reg_rvalid
  );
endinterface

// File: rtl/reg_mgt_mc.sv
// reg_mgt_mc: multi-channel register manager for NUM_CH TLK2711 links.
// Ports:
//   clk, rst          : single clock, asynchronous active-high reset
//   bus (slave)       : CPU register port (see reg_mgt_mc_if)
//   o_irq, o_irq_any  : per-channel interrupt level and its OR
//   o_tx_* / o_rx_*   : per-channel configuration, channel c in slice c
//   o_*_config_done   : one-cycle TX/RX start pulses
//   i_*_interrupt     : TX-done / RX-done / loss event pulses
//   i_rx_*            : RX packet report, valid with i_rx_interrupt
//   i_sync_loss, i_link_loss : live status levels, readable via irq_status
//   o_soft_rst        : datapath soft reset, SOFT_RST_CYCLES cycles long
// Address map: page 0 = global regs, page c+1 = channel c, offset in [7:0].
module reg_mgt_mc #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned SOFT_RST_CYCLES = 255,
  parameter logic [63:0] VERSION         = 64'h0000_0002_0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  reg_mgt_mc_if.slave                  bus,
  output logic [NUM_CH-1:0]            o_irq,
  output logic                         o_irq_any,
  output logic [NUM_CH*ADDR_WIDTH-1:0] o_tx_base_addr,
  output logic [NUM_CH*32-1:0]         o_tx_total_packet,
  output logic [NUM_CH*16-1:0]         o_tx_packet_body,
  output logic [NUM_CH*16-1:0]         o_tx_packet_tail,
  output logic [NUM_CH*16-1:0]         o_tx_body_num,
  output logic [NUM_CH*4-1:0]          o_tx_mode,
  output logic [NUM_CH-1:0]            o_tx_config_done,
  output logic [NUM_CH*ADDR_WIDTH-1:0] o_rx_base_addr,
  output logic [NUM_CH-1:0]            o_rx_config_done,
  input  logic [NUM_CH-1:0]            i_tx_interrupt,
  input  logic [NUM_CH-1:0]            i_rx_interrupt,
  input  logic [NUM_CH*32-1:0]         i_rx_total_packet,
  input  logic [NUM_CH*16-1:0]         i_rx_packet_tail,
  input  logic [NUM_CH*16-1:0]         i_rx_body_num,
  input  logic [NUM_CH-1:0]            i_loss_interrupt,
  input  logic [NUM_CH-1:0]            i_sync_loss,
  input  logic [NUM_CH-1:0]            i_link_loss,
  output logic                         o_soft_rst
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned IRQ_W = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [15:0] GLB_SRST = 16'h0000;
  localparam logic [15:0] GLB_IRQ  = 16'h0008;
  localparam logic [15:0] GLB_VER  = 16'h0010;

  localparam logic [7:0] OFF_TX_START = 8'h00;
  localparam logic [7:0] OFF_TX_BASE  = 8'h08;
  localparam logic [7:0] OFF_TX_TOTAL = 8'h10;
  localparam logic [7:0] OFF_TX_LEN   = 8'h18;
  localparam logic [7:0] OFF_TX_MODE  = 8'h20;
  localparam logic [7:0] OFF_RX_BASE  = 8'h28;
  localparam logic [7:0] OFF_RX_START = 8'h30;
  localparam logic [7:0] OFF_RX_RPT   = 8'h38;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h40;
  localparam logic [7:0] OFF_IRQ_MASK = 8'h48;

  // Stage 1: registered bus inputs
  logic        wen_q;
  logic [15:0] waddr_q;
  logic [63:0] wdata_q;
  logic        ren_q;
  logic [15:0] raddr_q;

  // Stage 2: decoded write, applied on the following edge
  logic [NUM_CH-1:0] wr_ch_d, wr_ch_q;
  logic [7:0]        wr_off_q;
  logic [63:0]       wr_data_q;
  logic              wr_srst_d, wr_srst_q;

  // Channel state
  logic [NUM_CH*AW-1:0]    tx_base_q, rx_base_q;
  logic [NUM_CH*32-1:0]    tx_total_q, rpt_total_q;
  logic [NUM_CH*16-1:0]    tx_body_q, tx_tail_q, tx_bnum_q;
  logic [NUM_CH*16-1:0]    rpt_tail_q, rpt_bnum_q;
  logic [NUM_CH*4-1:0]     tx_mode_q;
  logic [NUM_CH*IRQ_W-1:0] status_d, status_q, mask_q;
  logic [NUM_CH-1:0]       tx_start_d, tx_start_q, rx_start_d, rx_start_q;
  logic [NUM_CH-1:0]       irq_d, irq_q;
  logic                    irq_any_q;

  // Read path and soft reset
  logic [63:0]      rdata_d, rdata_q;
  logic             rvalid_q;
  logic [CNT_W-1:0] srst_cnt_q;
  logic             srst_q;

  // Data bits above the widest field are never stored
  logic unused_wdata;
  assign unused_wdata = ^wr_data_q[63:48];

  // Register the raw bus inputs once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
    end else begin
      wen_q   <= bus.i_reg_wen;
      waddr_q <= bus.i_reg_waddr;
      wdata_q <= bus.i_reg_wdata;
      ren_q   <= bus.i_reg_ren;
      raddr_q <= bus.i_reg_raddr;
    end
  end

  // Page decode: page c+1 selects channel c, pages past NUM_CH select nothing
  always_comb begin
    wr_ch_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ch_d[c] = wen_q && (waddr_q[15:8] == 8'(c + 1));
    end
    wr_srst_d = wen_q && (waddr_q == GLB_SRST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ch_q   <= '0;
      wr_off_q  <= '0;
      wr_data_q <= '0;
      wr_srst_q <= 1'b0;
    end else begin
      wr_ch_q   <= wr_ch_d;
      wr_off_q  <= waddr_q[7:0];
      wr_data_q <= wdata_q;
      wr_srst_q <= wr_srst_d;
    end
  end

  // Configuration banks, masks and RX report capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_base_q   <= '0;
      tx_total_q  <= '0;
      tx_body_q   <= '0;
      tx_tail_q   <= '0;
      tx_bnum_q   <= '0;
      tx_mode_q   <= '0;
      rx_base_q   <= '0;
      mask_q      <= '0;
      rpt_total_q <= '0;
      rpt_tail_q  <= '0;
      rpt_bnum_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch_q[c]) begin
          case (wr_off_q)
            OFF_TX_BASE:  tx_base_q[c*AW +: AW]  <= wr_data_q[AW-1:0];
            OFF_TX_TOTAL: tx_total_q[c*32 +: 32] <= wr_data_q[31:0];
            OFF_TX_LEN: begin
              tx_body_q[c*16 +: 16] <= wr_data_q[15:0];
              tx_tail_q[c*16 +: 16] <= wr_data_q[47:32];
            end
            OFF_TX_MODE: begin
              tx_mode_q[c*4 +: 4]   <= wr_data_q[3:0];
              tx_bnum_q[c*16 +: 16] <= wr_data_q[47:32];
            end
            OFF_RX_BASE:  rx_base_q[c*AW +: AW]     <= wr_data_q[AW-1:0];
            OFF_IRQ_MASK: mask_q[c*IRQ_W +: IRQ_W] <= wr_data_q[IRQ_W-1:0];
            default: ;
          endcase
        end
        if (i_rx_interrupt[c]) begin
          rpt_total_q[c*32 +: 32] <= i_rx_total_packet[c*32 +: 32];
          rpt_tail_q[c*16 +: 16]  <= i_rx_packet_tail[c*16 +: 16];
          rpt_bnum_q[c*16 +: 16]  <= i_rx_body_num[c*16 +: 16];
        end
      end
    end
  end

  // Start pulses, sticky status (set beats W1C clear) and masked irq
  always_comb begin
    tx_start_d = '0;
    rx_start_d = '0;
    status_d   = '0;
    irq_d      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tx_start_d[c] = wr_ch_q[c] && (wr_off_q == OFF_TX_START);
      rx_start_d[c] = wr_ch_q[c] && (wr_off_q == OFF_RX_START);
      status_d[c*IRQ_W +: IRQ_W] =
          (status_q[c*IRQ_W +: IRQ_W] &
           ~((wr_ch_q[c] && (wr_off_q == OFF_IRQ_STAT)) ? wr_data_q[IRQ_W-1:0] : 3'b000))
          | {i_loss_interrupt[c], i_rx_interrupt[c], i_tx_interrupt[c]};
      irq_d[c] = |(status_q[c*IRQ_W +: IRQ_W] & ~mask_q[c*IRQ_W +: IRQ_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start_q <= '0;
      rx_start_q <= '0;
      status_q   <= '0;
      irq_q      <= '0;
      irq_any_q  <= 1'b0;
    end else begin
      tx_start_q <= tx_start_d;
      rx_start_q <= rx_start_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
      irq_any_q  <= |irq_d;
    end
  end

  // Read mux; reads of write-only, unmapped or absent channels return 0
  always_comb begin
    rdata_d = '0;
    case (raddr_q)
      GLB_IRQ: rdata_d = 64'(irq_q);
      GLB_VER: rdata_d = VERSION;
      default: ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (raddr_q[15:8] == 8'(c + 1)) begin
        case (raddr_q[7:0])
          OFF_TX_BASE:  rdata_d = 64'(tx_base_q[c*AW +: AW]);
          OFF_TX_TOTAL: rdata_d = 64'(tx_total_q[c*32 +: 32]);
          OFF_TX_LEN:   rdata_d = {16'h0, tx_tail_q[c*16 +: 16], 16'h0, tx_body_q[c*16 +: 16]};
          OFF_TX_MODE:  rdata_d = {16'h0, tx_bnum_q[c*16 +: 16], 28'h0, tx_mode_q[c*4 +: 4]};
          OFF_RX_BASE:  rdata_d = 64'(rx_base_q[c*AW +: AW]);
          OFF_RX_RPT:   rdata_d = {rpt_bnum_q[c*16 +: 16], rpt_tail_q[c*16 +: 16],
                                   rpt_total_q[c*32 +: 32]};
          OFF_IRQ_STAT: rdata_d = {30'h0, i_sync_loss[c], i_link_loss[c], 29'h0,
                                   status_q[c*IRQ_W +: IRQ_W]};
          OFF_IRQ_MASK: rdata_d = {61'h0, mask_q[c*IRQ_W +: IRQ_W]};
          default: ;
        endcase
      end
    end
  end

  // Read data holds until the next accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= ren_q;
      if (ren_q) rdata_q <= rdata_d;
    end
  end

  // Soft reset: a trigger (re)loads the count, output drops as it expires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srst_cnt_q <= '0;
      srst_q     <= 1'b0;
    end else if (wr_srst_q) begin
      srst_cnt_q <= CNT_W'(SOFT_RST_CYCLES);
      srst_q     <= 1'b1;
    end else if (srst_cnt_q != '0) begin
      srst_cnt_q <= srst_cnt_q - CNT_W'(1);
      srst_q     <= (srst_cnt_q > CNT_W'(1));
    end
  end

  assign bus.o_reg_rdata  = rdata_q;
  assign bus.o_reg_rvalid = rvalid_q;
  assign o_irq             = irq_q;
  assign o_irq_any         = irq_any_q;
  assign o_tx_base_addr    = tx_base_q;
  assign o_tx_total_packet = tx_total_q;
  assign o_tx_packet_body  = tx_body_q;
  assign o_tx_packet_tail  = tx_tail_q;
  assign o_tx_body_num     = tx_bnum_q;
  assign o_tx_mode         = tx_mode_q;
  assign o_tx_config_done  = tx_start_q;
  assign o_rx_base_addr    = rx_base_q;
  assign o_rx_config_done  = rx_start_q;
  assign o_soft_rst        = srst_q;

endmodule

// File: tb/tb_reg_mgt_mc.sv
// tb_reg_mgt_mc: directed, table-driven bench for reg_mgt_mc (NUM_CH=2, 4-cycle soft reset).
module tb_reg_mgt_mc;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int SRC = 4;
  localparam logic [63:0] VER = 64'h0000_0002_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_mgt_mc_if bus ();

  logic [NCH-1:0]    irq, tx_done, rx_done;
  logic              irq_any, srst;
  logic [NCH*AW-1:0] tx_base, rx_base;
  logic [NCH*32-1:0] tx_total, rx_total;
  logic [NCH*16-1:0] tx_body, tx_tail, tx_bnum, rx_tail, rx_bnum;
  logic [NCH*4-1:0]  tx_mode;
  logic [NCH-1:0]    tx_int, rx_int, loss_int, sync_loss, link_loss;

  reg_mgt_mc #(
    .ADDR_WIDTH(AW), .NUM_CH(NCH), .SOFT_RST_CYCLES(SRC), .VERSION(VER)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_irq(irq), .o_irq_any(irq_any),
    .o_tx_base_addr(tx_base), .o_tx_total_packet(tx_total),
    .o_tx_packet_body(tx_body), .o_tx_packet_tail(tx_tail),
    .o_tx_body_num(tx_bnum), .o_tx_mode(tx_mode),
    .o_tx_config_done(tx_done), .o_rx_base_addr(rx_base),
    .o_rx_config_done(rx_done),
    .i_tx_interrupt(tx_int), .i_rx_interrupt(rx_int),
    .i_rx_total_packet(rx_total), .i_rx_packet_tail(rx_tail),
    .i_rx_body_num(rx_bnum), .i_loss_interrupt(loss_int),
    .i_sync_loss(sync_loss), .i_link_loss(link_loss),
    .o_soft_rst(srst)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    bus.i_reg_wen   = 1'b1;
    bus.i_reg_waddr = a;
    bus.i_reg_wdata = d;
    tick();
    bus.i_reg_wen   = 1'b0;
  endtask

  // Write and wait until the register has taken the value
  task automatic wr_settle(input logic [15:0] a, input logic [63:0] d);
    wr(a, d);
    tick();
    tick();
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [63:0] exp);
    bus.i_reg_ren   = 1'b1;
    bus.i_reg_raddr = a;
    tick();
    bus.i_reg_ren   = 1'b0;
    chk({name, "_rvalid_early"}, 64'(bus.o_reg_rvalid), 64'd0);
    tick();
    chk({name, "_rvalid"}, 64'(bus.o_reg_rvalid), 64'd1);
    chk(name, bus.o_reg_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int hi;
    tbl[0]  = '{1'b1, 16'h0108, 64'hFFFF_FFFF_1234_5678, 64'h0000_0000_1234_5678};
    tbl[1]  = '{1'b1, 16'h0110, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_CCCC_DDDD};
    tbl[2]  = '{1'b1, 16'h0118, 64'h1111_2222_3333_4444, 64'h0000_2222_0000_4444};
    tbl[3]  = '{1'b1, 16'h0120, 64'h0000_0005_0000_0002, 64'h0000_0005_0000_0002};
    tbl[4]  = '{1'b1, 16'h0228, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
    tbl[5]  = '{1'b1, 16'h0148, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0007};
    tbl[6]  = '{1'b1, 16'h0148, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    tbl[7]  = '{1'b0, 16'h0010, 64'h0,                   VER};
    tbl[8]  = '{1'b0, 16'h0500, 64'h0,                   64'h0};
    tbl[9]  = '{1'b0, 16'h0100, 64'h0,                   64'h0};
    tbl[10] = '{1'b0, 16'h0130, 64'h0,                   64'h0};
    tbl[11] = '{1'b0, 16'h0018, 64'h0,                   64'h0};
    tbl[12] = '{1'b0, 16'h0000, 64'h0,                   64'h0};
    tbl[13] = '{1'b0, 16'h0008, 64'h0,                   64'h0};

    rst = 1'b1;
    bus.i_reg_wen = 1'b0; bus.i_reg_waddr = '0; bus.i_reg_wdata = '0;
    bus.i_reg_ren = 1'b0; bus.i_reg_raddr = '0;
    tx_int = '0; rx_int = '0; loss_int = '0; sync_loss = '0; link_loss = '0;
    rx_total = '0; rx_tail = '0; rx_bnum = '0;
    tick();
    tick();

    // Reset state
    chk("rst_srst",    64'(srst), 64'd0);
    chk("rst_irq",     64'(irq), 64'd0);
    chk("rst_irq_any", 64'(irq_any), 64'd0);
    chk("rst_rvalid",  64'(bus.o_reg_rvalid), 64'd0);
    chk("rst_rdata",   bus.o_reg_rdata, 64'd0);
    chk("rst_tx_done", 64'(tx_done), 64'd0);
    chk("rst_tx_base", 64'(tx_base), 64'd0);
    chk("rst_tx_mode", 64'(tx_mode), 64'd0);
    rst = 1'b0;
    tick();

    // Register table: write (optional) then read back
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) wr_settle(tbl[i].addr, tbl[i].wdata);
      rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end
    chk("port_tx_base0",  64'(tx_base[31:0]),  64'h1234_5678);
    chk("port_tx_total0", 64'(tx_total[31:0]), 64'hCCCC_DDDD);
    chk("port_tx_tail0",  64'(tx_tail[15:0]),  64'h2222);
    chk("port_tx_mode0",  64'(tx_mode[3:0]),   64'h2);
    chk("port_tx_bnum0",  64'(tx_bnum[15:0]),  64'h5);
    chk("port_rx_base1",  64'(rx_base[63:32]), 64'hDEAD_BEEF);

    // TX base on ch1 then TX start pulse timing
    wr_settle(16'h0208, 64'h8000_0000);
    chk("t1_tx_base1", 64'(tx_base[63:32]), 64'h8000_0000);
    wr(16'h0200, 64'h0);
    chk("t1_done_e0", 64'(tx_done), 64'd0);
    tick();
    chk("t1_done_e1", 64'(tx_done), 64'd0);
    tick();
    chk("t1_done_e2", 64'(tx_done), 64'b10);
    tick();
    chk("t1_done_e3", 64'(tx_done), 64'd0);
    rd_chk("t1_rd_0208", 16'h0208, 64'h8000_0000);

    // RX start pulse on ch0
    wr(16'h0130, 64'h0);
    tick();
    tick();
    chk("rx_done_e2", 64'(rx_done), 64'b01);
    tick();
    chk("rx_done_e3", 64'(rx_done), 64'd0);

    // Back-to-back writes on consecutive cycles
    bus.i_reg_wen = 1'b1;
    bus.i_reg_waddr = 16'h0110; bus.i_reg_wdata = 64'h11;
    tick();
    bus.i_reg_waddr = 16'h0210; bus.i_reg_wdata = 64'h22;
    tick();
    bus.i_reg_waddr = 16'h0118; bus.i_reg_wdata = 64'h0000_0033_0000_0044;
    tick();
    bus.i_reg_wen = 1'b0;
    tick();
    tick();
    chk("b2b_total0", 64'(tx_total[31:0]),  64'h11);
    chk("b2b_total1", 64'(tx_total[63:32]), 64'h22);
    chk("b2b_body0",  64'(tx_body[15:0]),   64'h44);
    chk("b2b_tail0",  64'(tx_tail[15:0]),   64'h33);

    // Read and write of the same address in one cycle: read sees old value
    bus.i_reg_wen = 1'b1; bus.i_reg_waddr = 16'h0110; bus.i_reg_wdata = 64'h99;
    bus.i_reg_ren = 1'b1; bus.i_reg_raddr = 16'h0110;
    tick();
    bus.i_reg_wen = 1'b0; bus.i_reg_ren = 1'b0;
    tick();
    chk("rw_same_rvalid", 64'(bus.o_reg_rvalid), 64'd1);
    chk("rw_same_old",    bus.o_reg_rdata, 64'h11);
    tick();
    rd_chk("rw_same_new", 16'h0110, 64'h99);

    // RX report capture and rx_done interrupt on ch0
    rx_int = 2'b01;
    rx_total[31:0] = 32'h1234; rx_tail[15:0] = 16'h56; rx_bnum[15:0] = 16'h7;
    tick();
    rx_int = '0;
    rx_total = '1; rx_tail = '1; rx_bnum = '1;
    chk("t2_irq_lag", 64'(irq), 64'd0);
    tick();
    chk("t2_irq",     64'(irq), 64'b01);
    chk("t2_irq_any", 64'(irq_any), 64'd1);
    rd_chk("t2_status", 16'h0140, 64'h2);
    rd_chk("t2_report", 16'h0138, 64'h0007_0056_0000_1234);
    rd_chk("t2_summary", 16'h0008, 64'h1);
    wr_settle(16'h0140, 64'h2);
    tick();
    chk("t2_irq_clr",     64'(irq), 64'd0);
    chk("t2_irq_any_clr", 64'(irq_any), 64'd0);
    rd_chk("t2_status_clr", 16'h0140, 64'h0);
    rd_chk("t2_report_held", 16'h0138, 64'h0007_0056_0000_1234);
    rx_total = '0; rx_tail = '0; rx_bnum = '0;

    // Live link/sync loss levels in status read
    link_loss = 2'b01; sync_loss = 2'b01;
    rd_chk("live_loss_ch0", 16'h0140, 64'h0000_0003_0000_0000);
    rd_chk("live_loss_ch1", 16'h0240, 64'h0);
    link_loss = '0; sync_loss = '0;

    // Masked tx_done still sets status
    wr_settle(16'h0148, 64'h1);
    tx_int = 2'b01;
    tick();
    tx_int = '0;
    tick();
    tick();
    chk("t3_masked_irq", 64'(irq), 64'd0);
    rd_chk("t3_status", 16'h0140, 64'h1);
    wr_settle(16'h0148, 64'h0);
    tick();
    chk("t3_unmasked_irq", 64'(irq), 64'b01);

    // W1C and set of bit0 in the same cycle: set wins
    wr(16'h0140, 64'h1);
    tick();
    tx_int = 2'b01;
    tick();
    tx_int = '0;
    rd_chk("t4_set_wins", 16'h0140, 64'h1);
    wr_settle(16'h0140, 64'h1);
    tick();
    chk("t4_irq_clr", 64'(irq), 64'd0);
    rd_chk("t4_status_clr", 16'h0140, 64'h0);

    // Loss interrupt on ch1
    loss_int = 2'b10;
    tick();
    loss_int = '0;
    tick();
    chk("ch1_irq",     64'(irq), 64'b10);
    chk("ch1_irq_any", 64'(irq_any), 64'd1);
    rd_chk("ch1_status", 16'h0240, 64'h4);
    rd_chk("ch1_summary", 16'h0008, 64'h2);
    wr_settle(16'h0240, 64'h4);
    tick();
    chk("ch1_irq_clr", 64'(irq), 64'd0);

    // Single soft reset: exactly SRC cycles
    wr(16'h0000, 64'h0);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (srst) hi++;
      tick();
    end
    chk("srst_single_len", 64'(hi), 64'(SRC));

    // Re-trigger 2 cycles after the first write restarts the count
    bus.i_reg_wen = 1'b1; bus.i_reg_waddr = 16'h0000;
    tick();
    bus.i_reg_wen = 1'b0;
    tick();
    bus.i_reg_wen = 1'b1;
    tick();
    bus.i_reg_wen = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (srst) hi++;
      tick();
    end
    chk("srst_retrig_len", 64'(hi), 64'd6);
    rd_chk("srst_keeps_regs", 16'h0208, 64'h8000_0000);

    // Asynchronous reset in the middle of a soft reset
    rd_chk("t6_out_of_range", 16'h0500, 64'h0);
    wr(16'h0000, 64'h0);
    tick();
    tick();
    chk("t6_srst_on", 64'(srst), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_srst_async", 64'(srst), 64'd0);
    chk("t6_tx_base_async", 64'(tx_base), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_srst_stays_off", 64'(srst), 64'd0);
    rd_chk("t6_reg_cleared", 16'h0208, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
